shift_add_mult4: RTL and testbench

//  Sequential unsigned multiplier of WIDTH x WIDTH bits, producing a 2*WIDTH product.

---
 rtl/shift_add_mult4_pkg.sv | 25 ++
 rtl/full_adder.sv | 24 ++
 rtl/rca_nbit.sv | 36 +++
 rtl/shift_add_mult4.sv | 132 +++++++++++++
 tb/tb_shift_add_mult4.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult4_pkg.sv
// ---------------------------------------------------------------------------
// shift_add_mult4_pkg
// Shared definitions for the shift-add multiplier: FSM state encoding and the
// iteration-counter width helper.
// ---------------------------------------------------------------------------
package shift_add_mult4_pkg;

    // 2'd3 is unused; the multiplier decodes it as idle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mult_state_e;

    localparam int unsigned MultWidthDefault = 4;

    // The counter is loaded with the operand width itself, so it needs
    // clog2(width + 1) bits.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned CntWidthDefault = cnt_width(MultWidthDefault);

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full-adder cell.
// Ports:
//   a, b  in   addend bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/rca_nbit.sv
// ---------------------------------------------------------------------------
// rca_nbit
// Combinational WIDTH-bit ripple-carry adder built from full_adder cells.
// Ports:
//   a, b  in   WIDTH-bit addends
//   cin   in   carry into bit 0
//   s     out  WIDTH-bit sum
//   cout  out  carry out of the top bit
// ---------------------------------------------------------------------------
module rca_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (s[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult4.sv
// ---------------------------------------------------------------------------
// shift_add_mult4
// Sequential unsigned WIDTH x WIDTH multiplier using shift-add: one partial
// product add (through rca_nbit) and one right shift per clock.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   start    in   request, sampled only while idle
//   a, b     in   multiplicand / multiplier, captured on the accepted start
//   busy     out  high whenever not idle
//   done     out  one-cycle pulse when the product becomes valid
//   product  out  2*WIDTH-bit result, held until overwritten by the next run
// ---------------------------------------------------------------------------
module shift_add_mult4
    import shift_add_mult4_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    mult_state_e        state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               c_q, c_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               sum_c;

    // Partial product: multiplicand when the current multiplier LSB is set.
    assign addend = q_q[0] ? m_q : '0;

    rca_nbit #(
        .WIDTH(WIDTH)
    ) u_rca (
        .a   (acc_q),
        .b   (addend),
        .cin (1'b0),
        .s   (sum),
        .cout(sum_c)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_CALC: begin
                // {C,A,Q} <= {0, C', S, Q} >> 1: the adder carry becomes A's MSB.
                c_d   = 1'b0;
                acc_d = {sum_c, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    product_d = {sum_c, sum[WIDTH-1:1], sum[0], q_q[WIDTH-1:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                // Idle, and the unused encoding which behaves as idle.
                state_d = S_IDLE;
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = CntW'(WIDTH);
                    state_d = S_CALC;
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // C always shifts out as zero; it is held as a register but nothing reads it.
    logic unused_c;
    assign unused_c = c_q;

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult4.sv
module tb_shift_add_mult4;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    shift_add_mult4 #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a_in),
        .b      (b_in),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start makes the unit busy for W+1 cycles,
    // the last of which is the done cycle carrying a*b.
    int m_cnt  = 0;
    int m_prod = 0;
    int m_pend = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_prod <= 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  <= W + 1;
                m_pend <= int'(a_in) * int'(b_in);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_prod <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_vs_model", 16'(busy), 16'(m_cnt != 0));
            check("done_vs_model", 16'(done), 16'(m_cnt == 1));
            if (m_cnt <= 1) check("product_vs_model", 16'(product), 16'(m_prod));
        end
    end

    // One multiply: returns the product seen at done and the number of
    // edges after the accepting edge until done was seen.
    task automatic mult(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W-1:0] p, output int lat);
        @(negedge clk);
        start = 1'b1;
        a_in  = x;
        b_in  = y;
        @(negedge clk);
        start = 1'b0;
        a_in  = ~x;
        b_in  = ~y;
        check("busy_after_accept", 16'(busy), 16'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 16'd0, 16'd1);
        p = product;
        @(negedge clk);
    endtask

    logic [2*W-1:0] p;
    int lat;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 16'(busy), 16'd0);
        check("reset_done", 16'(done), 16'd0);
        check("reset_product", 16'(product), 16'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: 15*15
        mult(4'd15, 4'd15, p, lat);
        check("t1_product", 16'(p), 16'd225);
        check("t1_model", 16'(m_prod), 16'd225);
        check("t1_latency", 16'(lat), 16'd4);

        // 2: zero operands keep full latency
        mult(4'd0, 4'd9, p, lat);
        check("t2a_product", 16'(p), 16'd0);
        check("t2a_latency", 16'(lat), 16'd4);
        mult(4'd9, 4'd0, p, lat);
        check("t2b_product", 16'(p), 16'd0);
        check("t2b_latency", 16'(lat), 16'd4);

        // 3: start held high; no restart during CALC/DONE
        @(negedge clk);
        start = 1'b1;
        a_in  = 4'd6;
        b_in  = 4'd7;
        repeat (5) @(negedge clk);
        check("t3_done", 16'(done), 16'd1);
        check("t3_product", 16'(product), 16'd42);
        @(negedge clk);
        check("t3_idle_gap", 16'(busy), 16'd0);
        @(negedge clk);
        check("t3_restart", 16'(busy), 16'd1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t3_second_product", 16'(product), 16'd42);
        @(negedge clk);

        // 4: reset during the 2nd CALC cycle
        @(negedge clk);
        start = 1'b1;
        a_in  = 4'd13;
        b_in  = 4'd11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_busy", 16'(busy), 16'd0);
        check("t4_done", 16'(done), 16'd0);
        check("t4_product", 16'(product), 16'd0);
        rst_n = 1'b1;
        mult(4'd13, 4'd11, p, lat);
        check("t4_rerun", 16'(p), 16'd143);

        // 5: back-to-back, first product held while idle
        mult(4'd3, 4'd5, p, lat);
        check("t5a_product", 16'(p), 16'd15);
        repeat (3) begin
            @(negedge clk);
            check("t5_hold", 16'(product), 16'd15);
        end
        mult(4'd12, 4'd10, p, lat);
        check("t5b_product", 16'(p), 16'd120);

        // 6: exhaustive sweep
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            mult(v[7:4], v[3:0], p, lat);
            check("sweep_product", 16'(p), 16'(int'(v[7:4]) * int'(v[3:0])));
            check("sweep_latency", 16'(lat), 16'd4);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
